// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  mdu_pkg -- shared constants, state encoding and helpers for the MDU
//  Revision: 1.0
// ============================================================================
package mdu_pkg;

    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    localparam logic [5:0] ITER_COUNT  = 6'd32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } mdu_state_e;

    // 0x18..0x1B share the upper four funct bits.
    function automatic logic is_mdu_funct(input logic [5:0] funct);
        return (funct[5:2] == 4'b0110);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================================
//  mdu_step -- one shift-add (multiply) or restoring shift-subtract (divide)
//  iteration, purely combinational.
//  Revision: 1.0
// ============================================================================
module mdu_step (
    input  logic        is_div,
    input  logic [32:0] acc,
    input  logic [31:0] q,
    input  logic [32:0] opa,
    output logic [32:0] acc_nxt,
    output logic [31:0] q_nxt
);

    logic [33:0] sum;
    logic [33:0] diff;
    logic [32:0] shifted;

    always_comb begin
        sum     = {1'b0, acc} + (q[0] ? {1'b0, opa} : 34'd0);
        shifted = {acc[31:0], q[31]};
        diff    = {1'b0, shifted} - {1'b0, opa};
        if (is_div) begin
            // Remainder stays below the divisor, so the shifted value fits 33 bits.
            if (!diff[33]) begin
                acc_nxt = diff[32:0];
                q_nxt   = {q[30:0], 1'b1};
            end else begin
                acc_nxt = shifted;
                q_nxt   = {q[30:0], 1'b0};
            end
        end else begin
            acc_nxt = sum[33:1];
            q_nxt   = {sum[0], q[31:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  mdu_ctrl -- iterative mult/multu/div/divu unit owning the HI/LO registers
//  Revision: 1.0
// ============================================================================
module mdu_ctrl
    import mdu_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [5:0]  Function_opcode,
    input  logic [31:0] Read_data_1,
    input  logic [31:0] Read_data_2,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] hilo_wdata,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    mdu_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [32:0] acc_q, acc_d;
    logic [31:0] q_q, q_d;
    logic [32:0] opa_q, opa_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    logic        valid_start, op_signed;
    logic [32:0] ext_a, ext_b, abs_a, abs_b;
    logic [63:0] prod, prod_fix;
    logic [31:0] quo_fix, rem_fix;
    logic [32:0] step_acc;
    logic [31:0] step_q;

    mdu_step u_step (
        .is_div  (is_div_q),
        .acc     (acc_q),
        .q       (q_q),
        .opa     (opa_q),
        .acc_nxt (step_acc),
        .q_nxt   (step_q)
    );

    always_comb begin
        valid_start = start && is_mdu_funct(Function_opcode);
        op_signed   = !Function_opcode[0];
        ext_a       = {op_signed & Read_data_1[31], Read_data_1};
        ext_b       = {op_signed & Read_data_2[31], Read_data_2};
        abs_a       = ext_a[32] ? (33'd0 - ext_a) : ext_a;
        abs_b       = ext_b[32] ? (33'd0 - ext_b) : ext_b;
        prod        = {acc_q[31:0], q_q};
        prod_fix    = neg_res_q ? (64'd0 - prod) : prod;
        quo_fix     = neg_res_q ? (32'd0 - q_q) : q_q;
        rem_fix     = neg_rem_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        q_d       = q_q;
        opa_d     = opa_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;

        if (state_q == S_IDLE || state_q == S_DONE) begin
            if (hi_we) hi_d = hilo_wdata;
            if (lo_we) lo_d = hilo_wdata;
        end

        case (state_q)
            S_IDLE: begin
                if (valid_start) state_d = S_PREP;
            end
            S_PREP: begin
                is_div_d  = Function_opcode[1];
                neg_res_d = op_signed & (Read_data_1[31] ^ Read_data_2[31]);
                neg_rem_d = op_signed & Read_data_1[31];
                acc_d     = 33'd0;
                cnt_d     = ITER_COUNT;
                // Multiply: opa = multiplicand, q = multiplier. Divide: q = dividend, opa = divisor.
                opa_d     = Function_opcode[1] ? abs_b : abs_a;
                q_d       = Function_opcode[1] ? abs_a[31:0] : abs_b[31:0];
                if (Function_opcode[1] && Read_data_2 == 32'd0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    dbz_d   = 1'b1;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = step_acc;
                q_d   = step_q;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            acc_q     <= 33'd0;
            q_q       <= 32'd0;
            opa_q     <= 33'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            opa_q     <= opa_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    // Combinational so the accepting cycle already stalls the fetch stage.
    assign busy = reset_n & (((state_q == S_IDLE) & valid_start) | (state_q == S_PREP) |
                             (state_q == S_CALC) | (state_q == S_FIX));
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign HI          = hi_q;
    assign LO          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_mdu_ctrl -- table-driven and scoreboarded checks of mdu_ctrl
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  Function_opcode = 6'd0;
    logic [31:0] Read_data_1 = 32'd0;
    logic [31:0] Read_data_2 = 32'd0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] hilo_wdata = 32'd0;
    logic        busy, done, div_by_zero;
    logic [31:0] HI, LO;

    mdu_ctrl dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .Function_opcode (Function_opcode),
        .Read_data_1     (Read_data_1),
        .Read_data_2     (Read_data_2),
        .hi_we           (hi_we),
        .lo_we           (lo_we),
        .hilo_wdata      (hilo_wdata),
        .busy            (busy),
        .done            (done),
        .div_by_zero     (div_by_zero),
        .HI              (HI),
        .LO              (LO)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] rs, rt, pre_hi, pre_lo, exp_hi, exp_lo;
        logic        exp_dbz;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint      sp;
        logic [63:0] up;
        int          sq, sr;
        case (f)
            FUNCT_MULT:  begin sp = longint'($signed(a)) * longint'($signed(b)); {hi, lo} = sp; end
            FUNCT_MULTU: begin up = {32'd0, a} * {32'd0, b}; {hi, lo} = up; end
            FUNCT_DIV:   begin sq = $signed(a) / $signed(b); sr = $signed(a) % $signed(b); lo = sq; hi = sr; end
            default:     begin lo = a / b; hi = a % b; end
        endcase
    endfunction

    task automatic mt(input string tag, input logic [31:0] h, input logic [31:0] l);
        @(posedge clock); #1; hi_we = 1'b1; hilo_wdata = h;
        @(posedge clock); #1; hi_we = 1'b0; lo_we = 1'b1; hilo_wdata = l;
        @(posedge clock); #1; lo_we = 1'b0;
        @(negedge clock);
        chk({tag, " preload HI"}, HI, h);
        chk({tag, " preload LO"}, LO, l);
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] eh, input logic [31:0] el,
                          input logic edbz);
        exp_t e, got;
        int   cyc;
        bit   busy_ok;
        e.hi = eh; e.lo = el; e.dbz = edbz; e.lat = edbz ? 2 : 35;
        @(posedge clock); #1;
        start = 1'b1; Function_opcode = f; Read_data_1 = rs; Read_data_2 = rt;
        sb.push_back(e);
        cyc = 0; busy_ok = 1'b1;
        @(negedge clock);
        while (!done && cyc < 100) begin
            if (busy !== (cyc < e.lat)) busy_ok = 1'b0;
            @(negedge clock);
            cyc++;
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
        got = sb.pop_front();
        chk({tag, " latency"}, cyc, got.lat);
        chk({tag, " busy window"}, busy_ok, 1'b1);
        chk({tag, " HI"}, HI, got.hi);
        chk({tag, " LO"}, LO, got.lo);
        chk({tag, " div_by_zero"}, div_by_zero, got.dbz);
        @(posedge clock); #1; start = 1'b0;
        @(negedge clock);
        chk({tag, " done one-cycle"}, done, 1'b0);
    endtask

    vec_t tbl[10];

    initial begin
        logic [5:0]  rf;
        logic [31:0] ra, rb, mh, ml;
        int          cyc;
        bit          saw_done;

        tbl[0] = '{FUNCT_MULT,  32'd7,        32'hFFFFFFFD, 32'h1, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[1] = '{FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h3, 32'h4, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[2] = '{FUNCT_DIV,   32'hFFFFFFF9, 32'd2,        32'h5, 32'h6, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3] = '{FUNCT_DIVU,  32'd1234,     32'd0,        32'h11, 32'h22, 32'h11,     32'h22,       1'b1};
        tbl[4] = '{FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h7, 32'h8, 32'h0,        32'h80000000, 1'b0};
        tbl[5] = '{FUNCT_MULT,  32'h80000000, 32'h80000000, 32'h9, 32'hA, 32'h40000000, 32'h0,        1'b0};
        tbl[6] = '{FUNCT_DIVU,  32'd100,      32'd7,        32'hB, 32'hC, 32'd2,        32'd14,       1'b0};
        tbl[7] = '{FUNCT_DIV,   32'd7,        32'hFFFFFFFE, 32'hD, 32'hE, 32'd1,        32'hFFFFFFFD, 1'b0};
        tbl[8] = '{FUNCT_DIV,   32'hDEAD,     32'd0,        32'hAA, 32'hBB, 32'hAA,     32'hBB,       1'b1};
        tbl[9] = '{FUNCT_MULTU, 32'h80000000, 32'd2,        32'hF, 32'h10, 32'h1,       32'h0,        1'b0};

        // Reset state, with a valid request already on the inputs.
        start = 1'b1; Function_opcode = FUNCT_MULT;
        @(negedge clock);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset div_by_zero", div_by_zero, 1'b0);
        chk("reset HI", HI, 32'd0);
        chk("reset LO", LO, 32'd0);
        start = 1'b0;
        @(posedge clock); #1; reset_n = 1'b1;

        foreach (tbl[i]) begin
            mt($sformatf("vec%0d", i), tbl[i].pre_hi, tbl[i].pre_lo);
            run_op($sformatf("vec%0d", i), tbl[i].funct, tbl[i].rs, tbl[i].rt,
                   tbl[i].exp_hi, tbl[i].exp_lo, tbl[i].exp_dbz);
        end

        for (int i = 0; i < 8; i++) begin
            rf = FUNCT_MULT + 6'($urandom_range(0, 3));
            ra = $urandom; rb = $urandom;
            if (rf[1] && rb == 32'd0) rb = 32'd1;
            if (rf == FUNCT_DIV && rb == 32'hFFFFFFFF) rb = 32'd3;
            model(rf, ra, rb, mh, ml);
            run_op($sformatf("rnd%0d", i), rf, ra, rb, mh, ml, 1'b0);
        end

        // Unrecognised funct with start must be ignored.
        @(posedge clock); #1; start = 1'b1; Function_opcode = 6'h20;
        saw_done = 1'b0;
        @(negedge clock);
        chk("bad funct busy", busy, 1'b0);
        repeat (5) begin @(negedge clock); if (done) saw_done = 1'b1; end
        chk("bad funct no done", saw_done, 1'b0);
        @(posedge clock); #1; start = 1'b0;

        // mthi in the accepting cycle lands first, then the product overwrites it.
        @(posedge clock); #1;
        start = 1'b1; Function_opcode = FUNCT_MULT; Read_data_1 = 32'd3; Read_data_2 = 32'd5;
        hi_we = 1'b1; hilo_wdata = 32'hABCD;
        @(posedge clock); #1; hi_we = 1'b0;
        @(negedge clock);
        chk("same-cycle mthi applied", HI, 32'hABCD);
        cyc = 0;
        while (!done && cyc < 100) begin @(negedge clock); cyc++; end
        chk("same-cycle latency", cyc, 34);
        chk("same-cycle HI", HI, 32'd0);
        chk("same-cycle LO", LO, 32'd15);
        lo_we = 1'b1; hilo_wdata = 32'h77;
        @(posedge clock); #1; lo_we = 1'b0; start = 1'b0;
        @(negedge clock);
        chk("mtlo in DONE applied", LO, 32'h77);

        // Reset in the middle of a multiply.
        mt("abort", 32'h123, 32'h456);
        @(posedge clock); #1;
        start = 1'b1; Function_opcode = FUNCT_MULT; Read_data_1 = 32'd7; Read_data_2 = 32'd9;
        repeat (5) @(posedge clock);
        #1; lo_we = 1'b1; hilo_wdata = 32'h55;
        @(posedge clock); #1; lo_we = 1'b0;
        @(negedge clock);
        chk("mtlo in CALC dropped", LO, 32'h456);
        repeat (4) @(posedge clock);
        #3; reset_n = 1'b0;
        #1;
        chk("abort busy", busy, 1'b0);
        chk("abort HI", HI, 32'd0);
        chk("abort LO", LO, 32'd0);
        start = 1'b0;
        @(posedge clock); #1; reset_n = 1'b1;
        saw_done = 1'b0;
        repeat (45) begin @(negedge clock); if (done || busy) saw_done = 1'b1; end
        chk("abort no done", saw_done, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
